// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64 decode stage with valid/ready handshake, flush and illegal detection.
// Optional macro DECODE_MEXT_EN accepts R-type func7=0000001 (M extension).
module rv_decode_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      itype,
  output logic            rd_valid,
  output logic            rs1_valid,
  output logic            rs2_valid,
  output logic            func3_valid,
  output logic            func7_valid,
  output logic            imm_valid,
  output logic            illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      opc_p0, f7_p0;
  logic [2:0]      f3_p0;
  logic            r_p0, i_p0, s_p0, b_p0, u_p0, j_p0;
  logic            bad_p0, mext_p0;
  logic [31:0]     imm32_p0;
  logic [XLEN-1:0] imm_p0;
  logic            accept;

  assign opc_p0   = in_instr[6:0];
  assign f3_p0    = in_instr[14:12];
  assign f7_p0    = in_instr[31:25];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef DECODE_MEXT_EN
  assign mext_p0 = (f7_p0 == 7'b0000001);
`else
  assign mext_p0 = 1'b0;
`endif

  // p0: combinational decode of the incoming instruction
  always_comb begin
    bad_p0 = 1'b0;
    if (in_instr[1:0] != 2'b11) bad_p0 = 1'b1;
    if (!(opc_p0 inside {OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM,
                         OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL}))
      bad_p0 = 1'b1;
    if (opc_p0 == OP_R) begin
      if (!(f7_p0 == 7'b0000000 || f7_p0 == 7'b0100000 || mext_p0)) bad_p0 = 1'b1;
      if (f7_p0 == 7'b0100000 && !(f3_p0 == 3'b000 || f3_p0 == 3'b101)) bad_p0 = 1'b1;
    end
    if (opc_p0 == OP_IMM) begin
      if (f3_p0 == 3'b001 && f7_p0 != 7'b0000000) bad_p0 = 1'b1;
      if (f3_p0 == 3'b101 && !(f7_p0 == 7'b0000000 || f7_p0 == 7'b0100000)) bad_p0 = 1'b1;
      // RV32 shifts only have a 5-bit shamt
      if (XLEN == 32 && (f3_p0 == 3'b001 || f3_p0 == 3'b101) && in_instr[25]) bad_p0 = 1'b1;
    end

    r_p0 = !bad_p0 && (opc_p0 == OP_R);
    i_p0 = !bad_p0 && (opc_p0 inside {OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM});
    s_p0 = !bad_p0 && (opc_p0 == OP_STORE);
    b_p0 = !bad_p0 && (opc_p0 == OP_BRANCH);
    u_p0 = !bad_p0 && (opc_p0 inside {OP_LUI, OP_AUIPC});
    j_p0 = !bad_p0 && (opc_p0 == OP_JAL);

    imm32_p0 = 32'd0;
    if (i_p0) imm32_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
    if (s_p0) imm32_p0 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    if (b_p0) imm32_p0 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
    if (u_p0) imm32_p0 = {in_instr[31:12], 12'd0};
    if (j_p0) imm32_p0 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
    imm_p0 = sext32(imm32_p0);
  end

  // p1: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC_VAL;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func3       <= '0;
      func7       <= '0;
      opcode      <= '0;
      imm         <= '0;
      itype       <= '0;
      rd_valid    <= 1'b0;
      rs1_valid   <= 1'b0;
      rs2_valid   <= 1'b0;
      func3_valid <= 1'b0;
      func7_valid <= 1'b0;
      imm_valid   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        out_pc      <= in_pc;
        rs1         <= in_instr[19:15];
        rs2         <= in_instr[24:20];
        rd          <= in_instr[11:7];
        func3       <= f3_p0;
        func7       <= f7_p0;
        opcode      <= opc_p0;
        imm         <= imm_p0;
        itype       <= {r_p0, i_p0, s_p0, b_p0, u_p0, j_p0};
        rd_valid    <= (r_p0 || i_p0 || u_p0 || j_p0) && (in_instr[11:7] != 5'd0);
        rs1_valid   <= r_p0 || i_p0 || s_p0 || b_p0;
        rs2_valid   <= r_p0 || s_p0 || b_p0;
        func3_valid <= r_p0 || i_p0 || s_p0 || b_p0;
        func7_valid <= r_p0;
        imm_valid   <= i_p0 || s_p0 || b_p0 || u_p0 || j_p0;
        illegal     <= bad_p0;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Randomised bench for rv_decode_stage against a spec-level decode model plus directed literal checks.
module tb_rv_decode_stage;
  localparam int              XLEN = 32;
  localparam logic [XLEN-1:0] RPC  = 32'h0000_0080;

  logic            clk = 1'b0;
  logic            reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] out_pc, imm;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      func3;
  logic [6:0]      func7, opcode;
  logic [5:0]      itype;
  logic            rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid, imm_valid, illegal;

  rv_decode_stage #(.XLEN(XLEN), .RESET_PC_VAL(RPC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3), .func7(func7),
    .opcode(opcode), .imm(imm), .itype(itype), .rd_valid(rd_valid), .rs1_valid(rs1_valid),
    .rs2_valid(rs2_valid), .func3_valid(func3_valid), .func7_valid(func7_valid),
    .imm_valid(imm_valid), .illegal(illegal));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [XLEN-1:0] imm;
    logic [5:0] itype;
    logic rdv, rs1v, rs2v, f3v, f7v, immv, ill;
  } dec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Type index: 0=R 1=I 2=S 3=B 4=U 5=J, -1 = none/illegal
  function automatic dec_t model(input logic [31:0] x);
    dec_t d;
    int t;
    bit ill, mext;
    longint v;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = x[31:25];
    f3 = x[14:12];
`ifdef DECODE_MEXT_EN
    mext = 1;
`else
    mext = 0;
`endif
    case (x[6:0])
      7'h33: t = 0;
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: t = 1;
      7'h23: t = 2;
      7'h63: t = 3;
      7'h37, 7'h17: t = 4;
      7'h6F: t = 5;
      default: t = -1;
    endcase
    ill = (t < 0) || (x[1:0] != 2'b11);
    if (t == 0) begin
      if (!(f7 == 7'h00 || f7 == 7'h20 || (mext && f7 == 7'h01))) ill = 1;
      if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1;
    end
    if (x[6:0] == 7'h13) begin
      if (f3 == 3'd1 && f7 != 0) ill = 1;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1;
      if (XLEN == 32 && (f3 == 3'd1 || f3 == 3'd5) && x[25]) ill = 1;
    end
    if (ill) t = -1;
    case (t)
      1: v = $signed(x[31:20]);
      2: v = $signed({x[31:25], x[11:7]});
      3: v = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0});
      4: v = $signed({x[31:12], 12'h000});
      5: v = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0});
      default: v = 0;
    endcase
    d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.rd = x[11:7];
    d.f3 = f3; d.f7 = f7; d.opc = x[6:0];
    d.imm = v[XLEN-1:0];
    d.itype = (t >= 0) ? (6'b100000 >> t) : 6'b0;
    d.f7v  = (t == 0);
    d.rs2v = (t == 0 || t == 2 || t == 3);
    d.rs1v = (t >= 0 && t <= 3);
    d.f3v  = d.rs1v;
    d.immv = (t >= 1);
    d.rdv  = (t == 0 || t == 1 || t == 4 || t == 5) && (x[11:7] != 0);
    d.ill  = ill;
    return d;
  endfunction

  // Reference state of the stage
  logic            m_valid = 1'b0, m_known = 1'b0;
  logic [XLEN-1:0] m_pc = '0;
  dec_t            m_dec = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0; m_known <= 1'b1; m_pc <= RPC; m_dec <= '0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_dec <= model(in_instr);
        m_pc  <= in_pc;
        m_known <= !flush;
      end else if (flush) m_known <= 1'b0;
      if (flush) m_valid <= 1'b0;
      else if (in_valid && (!m_valid || out_ready)) m_valid <= 1'b1;
      else if (out_ready) m_valid <= 1'b0;
    end
  end

  logic started = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      if (m_known) begin
        chk("out_pc", out_pc, m_pc);
        chk("fields", {rs1, rs2, rd, func3, func7, opcode},
            {m_dec.rs1, m_dec.rs2, m_dec.rd, m_dec.f3, m_dec.f7, m_dec.opc});
        chk("imm", imm, m_dec.imm);
        chk("itype", itype, m_dec.itype);
        chk("flags", {rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid, imm_valid, illegal},
            {m_dec.rdv, m_dec.rs1v, m_dec.rs2v, m_dec.f3v, m_dec.f7v, m_dec.immv, m_dec.ill});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic ordy, input logic fl, input logic rst);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; reset = rst;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] OPS [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                                      7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  function automatic logic [31:0] gen_instr();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 19);
    if (k < 11) x[6:0] = OPS[k];
    else if (k < 17) x[6:0] = OPS[$urandom_range(0, 10)];
    case ($urandom_range(0, 4))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:25] = 7'h01;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    started = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, RPC);
    chk("rst_itype", itype, 0);

    drive(1, 32'h00500093, 32'h100, 1, 0, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_itype", itype, 6'b010000);
    chk("addi_rd", rd, 1);
    chk("addi_rs1", rs1, 0);
    chk("addi_imm", imm, 5);
    chk("addi_flags", {rd_valid, rs2_valid, illegal}, 3'b100);
    chk("addi_pc", out_pc, 32'h100);

    drive(1, 32'hFE000EE3, 32'h104, 1, 0, 0);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_itype", itype, 6'b000100);
    chk("beq_rdv", rd_valid, 0);

    drive(1, 32'h123452B7, 32'h108, 1, 0, 0);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", rd, 5);

    drive(1, 32'h00000013, 32'h10C, 1, 0, 0);
    chk("nop_rdv", rd_valid, 0);

    drive(1, 32'h022081B3, 32'h110, 1, 0, 0);
`ifdef DECODE_MEXT_EN
    chk("mul_ill", illegal, 0);
    chk("mul_itype", itype, 6'b100000);
`else
    chk("mul_ill", illegal, 1);
    chk("mul_itype", itype, 0);
    chk("mul_imm", imm, 0);
`endif

    drive(1, 32'hFFFFFFFF, 32'h114, 1, 0, 0);
    chk("ones_ill", illegal, 1);
    chk("ones_valid", out_valid, 1);

    // Stall for three cycles with a waiting instruction, then release
    drive(1, 32'h00500093, 32'h200, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h123452B7, 32'h204, 0, 0, 0);
      chk("stall_rdy", in_ready, 0);
      chk("stall_pc", out_pc, 32'h200);
    end
    drive(1, 32'h123452B7, 32'h204, 1, 0, 0);
    chk("rel_pc", out_pc, 32'h204);
    chk("rel_rd", rd, 5);
    drive(0, 0, 0, 1, 0, 0);
    chk("drain", out_valid, 0);

    drive(1, 32'h00500093, 32'h300, 1, 1, 0);
    chk("flush", out_valid, 0);

    drive(1, 32'h00500093, 32'h400, 1, 0, 0);
    drive(1, 32'hFE000EE3, 32'h404, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("rststall_valid", out_valid, 0);
    chk("rststall_pc", out_pc, RPC);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), XLEN'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) == 0);
    end
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
